// File: rtl/alu_issue.sv
// Decode-and-issue stage feeding the ALU: 16x32 register file, operand1 forwarding,
// and a single-cycle bubble for operand0 read-after-write hazards.
module alu_issue #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned IMM_W = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  input  logic [31:0] i_in_instr,
  output logic        o_in_ready,
  input  logic        i_hold,
  input  logic        i_wb_en,
  input  logic [3:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic [31:0] o_decoder_operand0,
  output logic [31:0] o_decoder_operand1,
  output logic [3:0]  o_operation,
  output logic        o_bitwise_op,
  output logic        o_add_or_subtract,
  output logic        o_update_flags,
  output logic        o_use_flags,
  output logic        o_nop,
  output logic [1:0]  o_sel,
  output logic [3:0]  o_wb_rd,
  output logic        o_wb_req,
  output logic        o_illegal
);

  localparam logic [3:0] OpAdd = 4'h0;
  localparam logic [3:0] OpSub = 4'h1;
  localparam logic [3:0] OpAnd = 4'h2;
  localparam logic [3:0] OpEor = 4'h4;
  localparam logic [3:0] OpMov = 4'h5;
  localparam logic [3:0] OpCmp = 4'h6;
  localparam logic [3:0] OpNop = 4'hF;

  localparam logic [1:0] SelReg = 2'b00;
  localparam logic [1:0] SelFwd = 2'b01;

  typedef enum logic [0:0] {StRun, StBubble} state_e;

  // Register file
  logic [31:0] r_regs [NREGS];

  // Issued slot (also serves as prev_rd / prev_wr for hazard checks)
  state_e      r_state;
  logic [31:0] r_op0;
  logic [31:0] r_op1;
  logic [3:0]  r_operation;
  logic        r_bitwise;
  logic        r_addsub;
  logic        r_update_flags;
  logic        r_use_flags;
  logic        r_nop;
  logic [1:0]  r_sel;
  logic [3:0]  r_wb_rd;
  logic        r_wb_req;
  logic        r_illegal;

  state_e      w_state_d;
  logic [31:0] w_op0_d;
  logic [31:0] w_op1_d;
  logic [3:0]  w_operation_d;
  logic        w_bitwise_d;
  logic        w_addsub_d;
  logic        w_update_flags_d;
  logic        w_use_flags_d;
  logic        w_nop_d;
  logic [1:0]  w_sel_d;
  logic [3:0]  w_wb_rd_d;
  logic        w_wb_req_d;
  logic        w_illegal_d;

  // Instruction fields
  logic [3:0]  w_opcode;
  logic        w_imm_sel;
  logic        w_upd_fld;
  logic        w_use_fld;
  logic [3:0]  w_rd;
  logic [3:0]  w_rn;
  logic [3:0]  w_rm;
  logic [31:0] w_imm_ext;
  logic        w_unused_instr_bit;

  assign w_opcode           = i_in_instr[31:28];
  assign w_imm_sel          = i_in_instr[27];
  assign w_upd_fld          = i_in_instr[26];
  assign w_use_fld          = i_in_instr[25];
  assign w_unused_instr_bit = i_in_instr[24];
  assign w_rd               = i_in_instr[23:20];
  assign w_rn               = i_in_instr[19:16];
  assign w_rm               = i_in_instr[15:12];
  assign w_imm_ext          = {{(32 - IMM_W){1'b0}}, i_in_instr[IMM_W-1:0]};

  // Combinational read with write-through so a same-cycle writeback is seen
  logic [31:0] w_rn_val;
  logic [31:0] w_rm_val;

  assign w_rn_val = (i_wb_en && (i_wb_addr == w_rn)) ? i_wb_data : r_regs[w_rn];
  assign w_rm_val = (i_wb_en && (i_wb_addr == w_rm)) ? i_wb_data : r_regs[w_rm];

  logic w_is_alu;
  logic w_is_illegal;
  logic w_uses_rn;
  logic w_op0_hazard;
  logic w_fwd;
  logic w_xfer;

  assign w_is_alu     = (w_opcode <= OpCmp);
  assign w_is_illegal = !w_is_alu && (w_opcode != OpNop);
  assign w_uses_rn    = w_is_alu && (w_opcode != OpMov);

  // Operand0 has no forward path, so a dependency on the issued result must bubble
  assign w_op0_hazard = i_in_valid && w_uses_rn && r_wb_req && (w_rn == r_wb_rd);
  assign w_fwd        = !w_imm_sel && r_wb_req && (w_rm == r_wb_rd);

  assign o_in_ready = !i_hold && !w_op0_hazard;
  assign w_xfer     = i_in_valid && o_in_ready;

  always_comb begin
    w_state_d        = r_state;
    w_op0_d          = r_op0;
    w_op1_d          = r_op1;
    w_operation_d    = r_operation;
    w_bitwise_d      = r_bitwise;
    w_addsub_d       = r_addsub;
    w_update_flags_d = r_update_flags;
    w_use_flags_d    = r_use_flags;
    w_nop_d          = r_nop;
    w_sel_d          = r_sel;
    w_wb_rd_d        = r_wb_rd;
    w_wb_req_d       = r_wb_req;
    w_illegal_d      = r_illegal;

    if (!i_hold) begin
      w_op0_d          = '0;
      w_op1_d          = '0;
      w_operation_d    = OpNop;
      w_bitwise_d      = 1'b0;
      w_addsub_d       = 1'b0;
      w_update_flags_d = 1'b0;
      w_use_flags_d    = 1'b0;
      w_nop_d          = 1'b1;
      w_sel_d          = SelReg;
      w_wb_rd_d        = '0;
      w_wb_req_d       = 1'b0;
      w_illegal_d      = 1'b0;

      if (w_xfer && w_is_alu) begin
        w_nop_d          = 1'b0;
        w_operation_d    = w_opcode;
        w_bitwise_d      = (w_opcode >= OpAnd) && (w_opcode <= OpEor);
        w_addsub_d       = (w_opcode == OpSub) || (w_opcode == OpCmp);
        w_update_flags_d = w_upd_fld || (w_opcode == OpCmp);
        w_use_flags_d    = w_use_fld;
        w_wb_rd_d        = w_rd;
        w_wb_req_d       = (w_opcode != OpCmp);
        w_op0_d          = (w_opcode == OpMov) ? '0 : w_rn_val;
        if (w_imm_sel) begin
          w_op1_d = w_imm_ext;
        end else if (w_fwd) begin
          // ALU substitutes its own last result for operand1
          w_op1_d = '0;
          w_sel_d = SelFwd;
        end else begin
          w_op1_d = w_rm_val;
        end
      end else if (w_xfer && w_is_illegal) begin
        w_illegal_d = 1'b1;
      end

      unique case (r_state)
        StRun:    w_state_d = w_op0_hazard ? StBubble : StRun;
        StBubble: w_state_d = StRun;
        default:  w_state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StRun;
      r_op0          <= '0;
      r_op1          <= '0;
      r_operation    <= OpNop;
      r_bitwise      <= 1'b0;
      r_addsub       <= 1'b0;
      r_update_flags <= 1'b0;
      r_use_flags    <= 1'b0;
      r_nop          <= 1'b1;
      r_sel          <= SelReg;
      r_wb_rd        <= '0;
      r_wb_req       <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_op0          <= w_op0_d;
      r_op1          <= w_op1_d;
      r_operation    <= w_operation_d;
      r_bitwise      <= w_bitwise_d;
      r_addsub       <= w_addsub_d;
      r_update_flags <= w_update_flags_d;
      r_use_flags    <= w_use_flags_d;
      r_nop          <= w_nop_d;
      r_sel          <= w_sel_d;
      r_wb_rd        <= w_wb_rd_d;
      r_wb_req       <= w_wb_req_d;
      r_illegal      <= w_illegal_d;
    end
  end

  // Writes continue under hold so the ALU writeback is never lost
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wb_en) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  assign o_decoder_operand0 = r_op0;
  assign o_decoder_operand1 = r_op1;
  assign o_operation        = r_operation;
  assign o_bitwise_op       = r_bitwise;
  assign o_add_or_subtract  = r_addsub;
  assign o_update_flags     = r_update_flags;
  assign o_use_flags        = r_use_flags;
  assign o_nop              = r_nop;
  assign o_sel              = r_sel;
  assign o_wb_rd            = r_wb_rd;
  assign o_wb_req           = r_wb_req;
  assign o_illegal          = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios then random traffic, each cycle compared
// against an instruction-level model of the issue stage.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        hold;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] op0;
  logic [31:0] op1;
  logic [3:0]  operation;
  logic        bitwise_op;
  logic        add_or_subtract;
  logic        update_flags;
  logic        use_flags;
  logic        nop;
  logic [1:0]  sel;
  logic [3:0]  wb_rd;
  logic        wb_req;
  logic        illegal;

  always #5 clk = ~clk;

  alu_issue #(.NREGS(16), .IMM_W(12)) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_in_valid         (in_valid),
    .i_in_instr         (in_instr),
    .o_in_ready         (in_ready),
    .i_hold             (hold),
    .i_wb_en            (wb_en),
    .i_wb_addr          (wb_addr),
    .i_wb_data          (wb_data),
    .o_decoder_operand0 (op0),
    .o_decoder_operand1 (op1),
    .o_operation        (operation),
    .o_bitwise_op       (bitwise_op),
    .o_add_or_subtract  (add_or_subtract),
    .o_update_flags     (update_flags),
    .o_use_flags        (use_flags),
    .o_nop              (nop),
    .o_sel              (sel),
    .o_wb_rd            (wb_rd),
    .o_wb_req           (wb_req),
    .o_illegal          (illegal)
  );

  typedef struct packed {
    logic [31:0] op0;
    logic [31:0] op1;
    logic [3:0]  operation;
    logic        bitw;
    logic        addsub;
    logic        upd;
    logic        usef;
    logic        nop;
    logic [1:0]  sel;
    logic [3:0]  wb_rd;
    logic        wb_req;
    logic        ill;
  } slot_t;

  slot_t       m_slot;
  logic [31:0] m_regs [16];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        last_ready;

  function automatic slot_t bubble_slot();
    slot_t s;
    s           = '0;
    s.operation = 4'hF;
    s.nop       = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] mk(input logic [3:0] op, input logic imm, input logic uf,
                                     input logic uu, input logic [3:0] rd, input logic [3:0] rn,
                                     input logic [3:0] rm, input logic [11:0] imm12);
    return {op, imm, uf, uu, 1'b0, rd, rn, rm, imm12};
  endfunction

  // Ready unless stalled, or the instruction needs operand0 from the slot now issued
  function automatic bit model_ready(input bit h, input bit v, input logic [31:0] ins);
    logic [3:0] op;
    bit         needs_rn;
    op       = ins[31:28];
    needs_rn = (op <= 4'h4) || (op == 4'h6);
    return !h && !(v && needs_rn && m_slot.wb_req && (m_slot.wb_rd == ins[19:16]));
  endfunction

  function automatic slot_t model_issue(input logic [31:0] ins, input bit we,
                                        input logic [3:0] wa, input logic [31:0] wd);
    slot_t       s;
    logic [3:0]  op;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [31:0] rnv;
    logic [31:0] rmv;
    s   = bubble_slot();
    op  = ins[31:28];
    rn  = ins[19:16];
    rm  = ins[15:12];
    rnv = (we && wa == rn) ? wd : m_regs[rn];
    rmv = (we && wa == rm) ? wd : m_regs[rm];
    if (op <= 4'h6) begin
      s.nop       = 1'b0;
      s.operation = op;
      s.bitw      = (op == 4'h2) || (op == 4'h3) || (op == 4'h4);
      s.addsub    = (op == 4'h1) || (op == 4'h6);
      s.upd       = (op == 4'h6) || ins[26];
      s.usef      = ins[25];
      s.wb_rd     = ins[23:20];
      s.wb_req    = (op != 4'h6);
      s.op0       = (op == 4'h5) ? 32'd0 : rnv;
      if (ins[27]) begin
        s.op1 = {20'd0, ins[11:0]};
      end else if (m_slot.wb_req && m_slot.wb_rd == rm) begin
        s.op1 = 32'd0;
        s.sel = 2'b01;
      end else begin
        s.op1 = rmv;
      end
    end else if (op != 4'hF) begin
      s.ill = 1'b1;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("operand0", op0, m_slot.op0);
    chk("operand1", op1, m_slot.op1);
    chk("operation", {28'd0, operation}, {28'd0, m_slot.operation});
    chk("bitwise_op", {31'd0, bitwise_op}, {31'd0, m_slot.bitw});
    chk("add_or_subtract", {31'd0, add_or_subtract}, {31'd0, m_slot.addsub});
    chk("update_flags", {31'd0, update_flags}, {31'd0, m_slot.upd});
    chk("use_flags", {31'd0, use_flags}, {31'd0, m_slot.usef});
    chk("nop", {31'd0, nop}, {31'd0, m_slot.nop});
    chk("sel", {30'd0, sel}, {30'd0, m_slot.sel});
    chk("wb_rd", {28'd0, wb_rd}, {28'd0, m_slot.wb_rd});
    chk("wb_req", {31'd0, wb_req}, {31'd0, m_slot.wb_req});
    chk("illegal", {31'd0, illegal}, {31'd0, m_slot.ill});
  endtask

  // One clock: drive at negedge, check ready before the edge, update model, check outputs
  task automatic cyc(input bit r, input bit v, input logic [31:0] ins, input bit h,
                     input bit we, input logic [3:0] wa, input logic [31:0] wd);
    bit exp_ready;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    in_instr = ins;
    hold     = h;
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    #1;
    last_ready = in_ready;
    exp_ready  = model_ready(h, v, ins);
    if (!r) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
      m_slot = bubble_slot();
    end else begin
      if (!h) m_slot = (v && exp_ready) ? model_issue(ins, we, wa, wd) : bubble_slot();
      if (we) m_regs[wa] = wd;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_wb(input logic [3:0] wa, input logic [31:0] wd);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, wa, wd);
  endtask

  logic [31:0] ins;
  logic [3:0]  rop;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; hold = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    m_slot = bubble_slot();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;

    // Reset state
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    chk("rst_nop", {31'd0, nop}, 32'd1);
    chk("rst_operation", {28'd0, operation}, 32'hF);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0);
    chk("rst_ready", {31'd0, last_ready}, 32'd1);

    // Preload r2 = 5, r3 = 7, then ADD r1 = r2 + r3
    idle_wb(4'd2, 32'd5);
    idle_wb(4'd3, 32'd7);
    cyc(1'b0, 1'b1, mk(4'h0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 12'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    chk("add_op0", op0, 32'd5);
    chk("add_op1", op1, 32'd7);
    chk("add_wb_rd", {28'd0, wb_rd}, 32'd1);

    // SUB r4 = r5 - r1 right after: operand1 forwarded
    cyc(1'b0, 1'b1, mk(4'h1, 1'b0, 1'b0, 1'b0, 4'd4, 4'd5, 4'd1, 12'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    chk("fwd_sel", {30'd0, sel}, 32'd1);
    chk("fwd_op1", op1, 32'd0);
    chk("fwd_sub", {31'd0, add_or_subtract}, 32'd1);

    // ADD r1 then ORR r6 = r1 | r2: one bubble, then operand0 via wb bypass
    cyc(1'b0, 1'b1, mk(4'h0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 12'd0), 1'b0, 1'b1, 4'd1, 32'd12);
    cyc(1'b0, 1'b1, mk(4'h3, 1'b0, 1'b0, 1'b0, 4'd6, 4'd1, 4'd2, 12'd0), 1'b0, 1'b1, 4'd4, 32'd99);
    chk("stall_ready", {31'd0, last_ready}, 32'd0);
    chk("stall_nop", {31'd0, nop}, 32'd1);
    cyc(1'b0, 1'b1, mk(4'h3, 1'b0, 1'b0, 1'b0, 4'd6, 4'd1, 4'd2, 12'd0), 1'b0, 1'b1, 4'd1, 32'h55);
    chk("bypass_ready", {31'd0, last_ready}, 32'd1);
    chk("bypass_op0", op0, 32'h55);
    chk("orr_bitwise", {31'd0, bitwise_op}, 32'd1);

    // Same-cycle write to rm
    cyc(1'b0, 1'b1, mk(4'h0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd0, 4'd3, 12'd0), 1'b0, 1'b1, 4'd3,
        32'hDEAD_BEEF);
    chk("wt_op1", op1, 32'hDEAD_BEEF);

    // Illegal opcode, then CMP
    cyc(1'b0, 1'b1, mk(4'h9, 1'b0, 1'b0, 1'b0, 4'd2, 4'd3, 4'd4, 12'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    chk("ill_pulse", {31'd0, illegal}, 32'd1);
    chk("ill_nop", {31'd0, nop}, 32'd1);
    cyc(1'b0, 1'b1, mk(4'h6, 1'b0, 1'b0, 1'b0, 4'd9, 4'd2, 4'd3, 12'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    chk("ill_drop", {31'd0, illegal}, 32'd0);
    chk("cmp_upd", {31'd0, update_flags}, 32'd1);
    chk("cmp_wbreq", {31'd0, wb_req}, 32'd0);

    // Immediate MOV
    cyc(1'b0, 1'b1, mk(4'h5, 1'b1, 1'b0, 1'b1, 4'd1, 4'd3, 4'd3, 12'hABC), 1'b0, 1'b0, 4'd0, 32'd0);
    chk("mov_op0", op0, 32'd0);
    chk("mov_imm", op1, 32'hABC);

    // Hold for 3 cycles freezes the ADD r1 slot
    cyc(1'b0, 1'b1, mk(4'h0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3, 12'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, mk(4'h2, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 12'd0), 1'b1, 1'b1, 4'd8,
          32'd3);
      chk("hold_ready", {31'd0, last_ready}, 32'd0);
      chk("hold_wb_rd", {28'd0, wb_rd}, 32'd1);
    end
    // Hazard into bubble, then reset during the bubble
    cyc(1'b0, 1'b1, mk(4'h3, 1'b0, 1'b0, 1'b0, 4'd6, 4'd1, 4'd2, 12'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    chk("pre_rst_ready", {31'd0, last_ready}, 32'd0);
    cyc(1'b1, 1'b1, mk(4'h3, 1'b0, 1'b0, 1'b0, 4'd6, 4'd1, 4'd2, 12'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    chk("post_rst_nop", {31'd0, nop}, 32'd1);
    chk("post_rst_sel", {30'd0, sel}, 32'd0);
    cyc(1'b0, 1'b1, mk(4'h3, 1'b0, 1'b0, 1'b0, 4'd6, 4'd1, 4'd2, 12'd0), 1'b0, 1'b0, 4'd0, 32'd0);
    chk("post_rst_ready", {31'd0, last_ready}, 32'd1);
    chk("post_rst_op0", op0, 32'd0);

    // Random traffic on a small register window so hazards are frequent
    for (int n = 0; n < 600; n++) begin
      rop = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
      ins = mk(rop, ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
               4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
               12'($urandom));
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ins,
          ($urandom_range(0, 9) == 0), 1'($urandom), 4'($urandom_range(0, 4)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
